// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Instruction fetch unit. It issues one memory request at a time,
//             queues the returned words with their PCs for decode, and
//             discards stale responses after a redirect.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_queue #(
  parameter int          N        = 64,
  parameter int          DEPTH    = 4,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     PCSrc_F,
  input  logic [N-1:0]             PCBranch_F,
  output logic [N-1:0]             imem_addr_F,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  input  logic                     imem_rsp_valid,
  input  logic [31:0]              imem_rsp_data,
  output logic                     instr_valid_D,
  output logic [31:0]              instr_D,
  output logic [N-1:0]             pc_D,
  input  logic                     instr_ready_D,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,  // free to issue a request
    ST_WAIT = 2'd1,  // one request outstanding, response will be queued
    ST_KILL = 2'd2   // one request outstanding, response will be dropped
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    pc_q, pc_d;
  logic [N-1:0]    req_pc_q, req_pc_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [N-1:0]    ent_pc_q    [DEPTH];
  logic [N-1:0]    ent_pc_d    [DEPTH];
  logic [31:0]     ent_instr_q [DEPTH];
  logic [31:0]     ent_instr_d [DEPTH];

  logic            handshake;
  logic            push;
  logic            pop;
  logic            unused_pcbranch_low;

  // Redirect targets are word aligned, so the low target bits are dropped.
  assign unused_pcbranch_low = ^PCBranch_F[1:0];

  // Request, push and pop qualifiers; a redirect cancels both queue updates.
  always_comb begin
    imem_req_valid = reset && (state_q == ST_REQ) && (count_q < CW'(DEPTH));
    handshake      = imem_req_valid && imem_req_ready;
    push           = (state_q == ST_WAIT) && imem_rsp_valid && !PCSrc_F;
    pop            = (count_q != '0) && instr_ready_D && !PCSrc_F;
    imem_addr_F    = pc_q;
    instr_valid_D  = (count_q != '0);
    instr_D        = ent_instr_q[head_q];
    pc_D           = ent_pc_q[head_q];
    q_count        = count_q;
  end

  // Next-state logic for the FSM, PC, pointers and occupancy.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    if (PCSrc_F) begin
      pc_d    = {PCBranch_F[N-1:2], 2'b00};
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
      case (state_q)
        ST_WAIT, ST_KILL: state_d = imem_rsp_valid ? ST_REQ : ST_KILL;
        default:          state_d = handshake ? ST_KILL : ST_REQ;
      endcase
    end else begin
      case (state_q)
        ST_REQ: begin
          if (handshake) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + {{(N-3){1'b0}}, 3'd4};
            state_d  = ST_WAIT;
          end
        end
        ST_WAIT: if (imem_rsp_valid) state_d = ST_REQ;
        ST_KILL: if (imem_rsp_valid) state_d = ST_REQ;
        default: state_d = ST_REQ;
      endcase
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Queue storage: write the returned word and its PC at the tail on a push.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_pc_d[i]    = ent_pc_q[i];
      ent_instr_d[i] = ent_instr_q[i];
    end
    if (push) begin
      ent_pc_d[tail_q]    = req_pc_q;
      ent_instr_d[tail_q] = imem_rsp_data;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc_q[i]    <= '0;
        ent_instr_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc_q[i]    <= ent_pc_d[i];
        ent_instr_q[i] <= ent_instr_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Randomized self-checking bench for fetch_queue against a
//             transaction-level model (PC, one outstanding request, queue).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

  localparam int          N        = 64;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk;
  logic        reset;
  logic        PCSrc_F;
  logic [63:0] PCBranch_F;
  logic [63:0] imem_addr_F;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid_D;
  logic [31:0] instr_D;
  logic [63:0] pc_D;
  logic        instr_ready_D;
  logic [2:0]  q_count;

  fetch_queue #(.N(N), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .PCSrc_F        (PCSrc_F),
    .PCBranch_F     (PCBranch_F),
    .imem_addr_F    (imem_addr_F),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid_D  (instr_valid_D),
    .instr_D        (instr_D),
    .pc_D           (pc_D),
    .instr_ready_D  (instr_ready_D),
    .q_count        (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  // Reference model state
  ent_t        mq[$];
  logic [63:0] m_pc;
  logic [63:0] m_req;
  bit          m_out;
  bit          m_kill;
  int          m_cnt;

  // Stimulus knobs
  bit rst_val;
  bit force_stale;
  int rdy_pct, pop_pct, redir_pct, spur_pct, rst_pct;
  int lat_lo, lat_hi;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] issued[$];
  logic [63:0] popped[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc   = RESET_PC;
    m_req  = '0;
    m_out  = 1'b0;
    m_kill = 1'b0;
    m_cnt  = 0;
    mq.delete();
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance the model.
  task automatic step(input bit redir, input logic [63:0] tgt);
    bit   exp_rv, hs, pop, was_out;
    ent_t e;
    reset          = rst_val;
    imem_req_ready = force_stale ? 1'b0 : ($urandom_range(99) < rdy_pct);
    instr_ready_D  = ($urandom_range(99) < pop_pct);
    PCSrc_F        = redir || ($urandom_range(99) < redir_pct);
    PCBranch_F     = redir ? tgt : {$urandom, $urandom};
    imem_rsp_data  = $urandom;
    if (force_stale)  imem_rsp_valid = 1'b1;
    else if (m_out)   imem_rsp_valid = (m_cnt == 0);
    else              imem_rsp_valid = ($urandom_range(99) < spur_pct);
    if (!rst_val) model_reset();
    #1;
    exp_rv = rst_val && !m_out && (mq.size() < DEPTH);
    chk("req_valid",   imem_req_valid, exp_rv);
    chk("imem_addr",   imem_addr_F, m_pc);
    chk("q_count",     q_count, mq.size());
    chk("instr_valid", instr_valid_D, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("pc_D",    pc_D, mq[0].pc);
      chk("instr_D", instr_D, mq[0].ins);
    end
    if (imem_req_valid && imem_req_ready) issued.push_back(imem_addr_F);
    if (instr_valid_D && instr_ready_D && !PCSrc_F) popped.push_back(pc_D);

    if (rst_val) begin
      was_out = m_out;
      hs      = exp_rv && imem_req_ready;
      pop     = (mq.size() != 0) && instr_ready_D;
      if (PCSrc_F) begin
        m_pc = {PCBranch_F[63:2], 2'b00};
        mq.delete();
        if (m_out) begin
          if (imem_rsp_valid) m_out = 1'b0;
          else                m_kill = 1'b1;
        end else if (hs) begin
          m_out  = 1'b1;
          m_kill = 1'b1;
          m_cnt  = $urandom_range(lat_hi, lat_lo);
        end
      end else begin
        if (pop) void'(mq.pop_front());
        if (m_out && imem_rsp_valid) begin
          if (!m_kill) begin
            e.pc  = m_req;
            e.ins = imem_rsp_data;
            mq.push_back(e);
          end
          m_out = 1'b0;
        end
        if (hs) begin
          m_req  = m_pc;
          m_pc   = m_pc + 64'd4;
          m_out  = 1'b1;
          m_kill = 1'b0;
          m_cnt  = $urandom_range(lat_hi, lat_lo);
        end
      end
      if (was_out && m_out && m_cnt > 0) m_cnt--;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; PCSrc_F = 1'b0; PCBranch_F = '0; imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; instr_ready_D = 1'b0;
    rst_val = 1'b0; force_stale = 1'b0;
    rdy_pct = 100; pop_pct = 0; redir_pct = 0; spur_pct = 0; rst_pct = 0;
    lat_lo = 0; lat_hi = 0;
    model_reset();
    @(negedge clk);

    // Held in reset with memory ready: nothing may be requested.
    for (int i = 0; i < 5; i++) step(1'b0, '0);

    // Release with single-cycle memory and no decode pops: queue fills.
    rst_val = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, '0);
    chk("fill_count", q_count, 64'd4);
    chk("fill_stop_valid", imem_req_valid, 64'd0);
    chk("fill_stop_addr", imem_addr_F, 64'h10);
    chk("fill_head_pc", pc_D, 64'h0);

    // Redirect while a request is outstanding; its response must be dropped.
    lat_lo = 3; lat_hi = 3;
    pop_pct = 100; step(1'b0, '0);
    pop_pct = 0;   step(1'b0, '0);
    step(1'b1, 64'h16e10b5ef5732a68);
    chk("kill_count", q_count, 64'd0);
    issued.delete();
    for (int i = 0; i < 8; i++) step(1'b0, '0);
    chk("kill_next_addr", (issued.size() > 0) ? issued[0] : 64'hDEAD, 64'h16e10b5ef5732a68);

    // Redirect to the top of the address space: alignment and wrap.
    lat_lo = 0; lat_hi = 0;
    step(1'b1, 64'hFFFFFFFFFFFFFFFF);
    issued.delete();
    for (int i = 0; i < 8; i++) step(1'b0, '0);
    chk("wrap_first",  (issued.size() > 0) ? issued[0] : 64'hDEAD, 64'hFFFFFFFFFFFFFFFC);
    chk("wrap_second", (issued.size() > 1) ? issued[1] : 64'hDEAD, 64'h0);

    // Full queue, then pop every cycle so pushes coincide with pops.
    for (int i = 0; i < 10; i++) step(1'b0, '0);
    popped.delete();
    pop_pct = 100;
    for (int i = 0; i < 20; i++) step(1'b0, '0);
    chk("pop_seen", popped.size() >= 4, 64'd1);
    for (int i = 1; i < popped.size(); i++) chk("pop_order", popped[i], popped[i-1] + 64'd4);

    // Reset while waiting, then a stale response right after release.
    pop_pct = 0; lat_lo = 5; lat_hi = 5;
    for (int i = 0; i < 10 && !m_out; i++) step(1'b0, '0);
    chk("reached_wait", m_out, 64'd1);
    rst_val = 1'b0;
    step(1'b0, '0);
    step(1'b0, '0);
    rst_val = 1'b1; force_stale = 1'b1;
    issued.delete();
    step(1'b0, '0);
    force_stale = 1'b0;
    chk("stale_count", q_count, 64'd0);
    lat_lo = 0; lat_hi = 0;
    for (int i = 0; i < 4; i++) step(1'b0, '0);
    chk("stale_next_addr", (issued.size() > 0) ? issued[0] : 64'hDEAD, RESET_PC);

    // Random traffic: latency, back-pressure, pops, redirects, spurious responses, resets.
    rdy_pct = 70; pop_pct = 50; redir_pct = 5; spur_pct = 10; rst_pct = 1;
    lat_lo = 0; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      rst_val = ($urandom_range(99) >= rst_pct);
      step(1'b0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter N, default 64: PC/address width in bits (N >= 8).
REQ-002 Parameter DEPTH, default 4: instruction-queue entries (power of two, >= 2).
REQ-003 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-004 Signal clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Signal reset  input  1: asynchronous, active-low reset (asserted at 0).
REQ-006 Signal PCSrc_F  input  1: redirect strobe; 1 = take PCBranch_F this cycle.
REQ-007 Signal PCBranch_F  input  N: redirect target address.
REQ-008 Signal imem_addr_F  output  N: current fetch PC; the request address whenever imem_req_valid = 1.
REQ-009 Signal imem_req_valid  output  1: fetch request to instruction memory.
REQ-010 Signal imem_req_ready  input  1: memory accepts the request when both are 1.
REQ-011 Signal imem_rsp_valid  input  1: instruction-word response strobe.
REQ-012 Signal imem_rsp_data  input  32: instruction word.
REQ-013 Signal instr_valid_D  output  1: queue head valid (count != 0).
REQ-014 Signal instr_D  output  32: queue-head instruction.
REQ-015 Signal pc_D  output  N: PC of the queue-head instruction.
REQ-016 Signal instr_ready_D  input  1: decode pops the head when instr_valid_D && instr_ready_D.
REQ-017 Signal q_count  output  $clog2(DEPTH)+1: number of occupied queue entries.

Function
REQ-018 FSM states SHALL be REQ (may issue), WAIT (one request outstanding), KILL (outstanding response to be discarded); at most one request is outstanding.
REQ-019 imem_req_valid SHALL be combinationally 1 only in REQ with q_count < DEPTH, and 0 while reset is asserted.
REQ-020 On REQ with a handshake and PCSrc_F = 0: latch req_pc = PC, PC <= PC + 4 modulo 2^N (wraps silently), state -> WAIT.
REQ-021 In WAIT, imem_rsp_valid = 1 with PCSrc_F = 0 SHALL push {req_pc, imem_rsp_data} to the queue tail and return to REQ; response latency is unbounded.
REQ-022 In KILL, imem_rsp_valid = 1 SHALL discard the data and return to REQ.
REQ-023 imem_rsp_valid in REQ SHALL be ignored.
REQ-024 PCSrc_F = 1 SHALL have top priority: PC <= {PCBranch_F[N-1:2], 2'b00}, queue flushed (q_count <= 0), any same-cycle pop or push cancelled.
REQ-025 State on redirect: from WAIT -> KILL unless a response arrives that cycle (then REQ); from KILL -> KILL unless a response arrives (then REQ); from REQ with a same-cycle handshake -> KILL; otherwise REQ.
REQ-026 Simultaneous push and pop SHALL leave q_count unchanged, with head/tail pointers both advancing modulo DEPTH.
REQ-027 Pop on an empty queue SHALL have no effect; push is never blocked because issue is gated on free space (REQ-019).
REQ-028 instr_D/pc_D SHALL reflect the head entry combinationally; content is don't-care when instr_valid_D = 0.

Reset
REQ-029 While reset = 0, asynchronously: PC = RESET_PC, state = REQ, q_count = 0, pointers = 0, req_pc = 0, imem_req_valid = 0, instr_valid_D = 0.
REQ-030 Reset asserted mid-operation SHALL abandon any outstanding request; a late response after release arrives in REQ and is ignored.
REQ-031 First request SHALL be issued in the first cycle after release, with imem_addr_F = RESET_PC.

Verification
REQ-032 reset = 0 for 5 cycles with imem_req_ready = 1 -> imem_req_valid = 0, imem_addr_F = 0, q_count = 0 throughout.
REQ-033 Release reset; 1-cycle memory latency; instr_ready_D = 0 -> queue holds pc_D 0x0, 0x4, 0x8, 0xC; q_count = 4; imem_req_valid drops to 0 with imem_addr_F = 0x10.
REQ-034 In WAIT, pulse PCSrc_F = 1 with PCBranch_F = 64'h16e10b5ef5732a68 -> q_count = 0, state KILL; the response is dropped; next request address = 64'h16e10b5ef5732a68.
REQ-035 Redirect to 64'hFFFFFFFFFFFFFFFF -> first request 64'hFFFFFFFFFFFFFFFC, second request 64'h0.
REQ-036 Full queue with instr_ready_D = 1 and a response arriving on the same cycle as a pop -> q_count stays constant; pc_D sequence stays in order with no duplicates.
REQ-037 Assert reset while in WAIT, release, then deliver a stale response -> response ignored, q_count = 0, next request address = RESET_PC.
